// File: rtl/dft_accum_stream_if.sv
// Sample, control and result signals of the windowed-DFT bin accumulator.
// The slave modport is the accumulator's view; master is the AFE/APU side.
interface dft_accum_stream_if #(
    parameter int IQ_WIDTH           = 16,
    parameter int WINDOW_WIDTH       = 16,
    parameter int OSC_WIDTH          = 18,
    parameter int ACCUM_WIDTH        = 48,
    parameter int NUM_BINS           = 16,
    parameter int SAMPLE_COUNT_WIDTH = 16
);
    localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    logic                           start_i;
    logic                           abort_i;
    logic                           s_valid_i;
    logic                           s_ready_o;
    logic                           s_last_i;
    logic signed [IQ_WIDTH-1:0]     i_sample_i;
    logic signed [IQ_WIDTH-1:0]     q_sample_i;
    logic signed [WINDOW_WIDTH-1:0] window_coeff_i;
    logic signed [OSC_WIDTH-1:0]    W_real_i [NUM_BINS];
    logic signed [OSC_WIDTH-1:0]    W_imag_i [NUM_BINS];
    logic                           m_valid_o;
    logic                           m_ready_i;
    logic [BIN_W-1:0]               m_bin_o;
    logic signed [ACCUM_WIDTH-1:0]  m_real_o;
    logic signed [ACCUM_WIDTH-1:0]  m_imag_o;
    logic                           m_last_o;
    logic                           ovf_o;
    logic [SAMPLE_COUNT_WIDTH-1:0]  sample_count_o;
    logic                           busy_o;

    modport master (
        output start_i, abort_i, s_valid_i, s_last_i, i_sample_i, q_sample_i,
               window_coeff_i, W_real_i, W_imag_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_bin_o, m_real_o, m_imag_o, m_last_o,
               ovf_o, sample_count_o, busy_o
    );

    modport slave (
        input  start_i, abort_i, s_valid_i, s_last_i, i_sample_i, q_sample_i,
               window_coeff_i, W_real_i, W_imag_i, m_ready_i,
        output s_ready_o, m_valid_o, m_bin_o, m_real_o, m_imag_o, m_last_o,
               ovf_o, sample_count_o, busy_o
    );
endinterface

// File: rtl/dft_accum_stream.sv
// Windowed-DFT bin accumulator: x[n]*h[n]*W[n,k] per bin in a 3-stage pipeline,
// saturating accumulation, then serial bin readout over valid/ready.
module dft_accum_stream #(
    parameter int IQ_WIDTH           = 16,
    parameter int WINDOW_WIDTH       = 16,
    parameter int OSC_WIDTH          = 18,
    parameter int ACCUM_WIDTH        = 48,
    parameter int NUM_BINS           = 16,
    parameter int PROD_SHIFT         = 0,
    parameter int SAMPLE_COUNT_WIDTH = 16
) (
    input logic               clk_i,
    input logic               rst_ni,
    dft_accum_stream_if.slave bus
);
    localparam int XW     = IQ_WIDTH + WINDOW_WIDTH;
    localparam int PW     = XW + OSC_WIDTH + 1;
    localparam int TW     = ACCUM_WIDTH + 1;
    localparam int BIN_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int RND_SH = (PROD_SHIFT > 0) ? PROD_SHIFT - 1 : 0;
    localparam logic signed [ACCUM_WIDTH-1:0] ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_WIDTH-1:0] ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUTPUT} state_t;

    function automatic logic signed [XW-1:0] mul_x(input logic signed [IQ_WIDTH-1:0] a,
                                                   input logic signed [WINDOW_WIDTH-1:0] b);
        logic signed [XW-1:0] ae, be;
        ae = XW'(a);
        be = XW'(b);
        return ae * be;
    endfunction

    function automatic logic signed [PW-1:0] mul_p(input logic signed [XW-1:0] a,
                                                   input logic signed [OSC_WIDTH-1:0] b);
        logic signed [PW-1:0] ae, be;
        ae = PW'(a);
        be = PW'(b);
        return ae * be;
    endfunction

    function automatic logic signed [TW-1:0] scale(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        if (PROD_SHIFT > 0) r = (p + (PW'(1) <<< RND_SH)) >>> PROD_SHIFT;
        else                r = p;
        return TW'(r);
    endfunction

    // MSB of the result flags a clamp; low ACCUM_WIDTH bits are the new sum.
    function automatic logic [ACCUM_WIDTH:0] sat_add(input logic signed [ACCUM_WIDTH-1:0] a,
                                                     input logic signed [TW-1:0] t);
        logic signed [TW-1:0] s;
        s = TW'(a) + t;
        if (s[TW-1] != s[TW-2]) return {1'b1, s[TW-1] ? ACC_MIN : ACC_MAX};
        return {1'b0, s[ACCUM_WIDTH-1:0]};
    endfunction

    state_t                         state, state_nxt;
    logic                           flush_cnt;
    logic [BIN_W-1:0]               bin_idx;
    logic                           accept, out_hs, run_start, ovf_q;
    logic [SAMPLE_COUNT_WIDTH-1:0]  count_q;

    logic signed [XW-1:0]           xr_p1, xi_p1;
    logic signed [OSC_WIDTH-1:0]    wr_p1 [NUM_BINS];
    logic signed [OSC_WIDTH-1:0]    wi_p1 [NUM_BINS];
    logic                           vld_p1, vld_p2;
    logic signed [PW-1:0]           pr_p2 [NUM_BINS];
    logic signed [PW-1:0]           pi_p2 [NUM_BINS];
    logic signed [ACCUM_WIDTH-1:0]  acc_re [NUM_BINS];
    logic signed [ACCUM_WIDTH-1:0]  acc_im [NUM_BINS];
    logic [ACCUM_WIDTH:0]           sum_re [NUM_BINS];
    logic [ACCUM_WIDTH:0]           sum_im [NUM_BINS];
    logic                           any_ovf;

    assign accept    = (state == ACCUM) && bus.s_valid_i;
    assign out_hs    = (state == OUTPUT) && bus.m_ready_i;
    assign run_start = (state == IDLE) && bus.start_i && !bus.abort_i;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_i) state_nxt = ACCUM;
            ACCUM:   if (accept && bus.s_last_i) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt) state_nxt = OUTPUT;
            OUTPUT:  if (out_hs && bin_idx == BIN_W'(NUM_BINS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
            bin_idx   <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            if (state_nxt != OUTPUT) bin_idx <= '0;
            else if (out_hs)         bin_idx <= bin_idx + 1'b1;
        end
    end

    // Valid tags: abort drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.abort_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1: window the sample, capture W alongside it.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            xr_p1 <= mul_x(bus.i_sample_i, bus.window_coeff_i);
            xi_p1 <= mul_x(bus.q_sample_i, bus.window_coeff_i);
            wr_p1 <= bus.W_real_i;
            wi_p1 <= bus.W_imag_i;
        end
    end

    // Stage 2: full-width complex product per bin.
    always_ff @(posedge clk_i) begin
        if (vld_p1) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                pr_p2[k] <= mul_p(xr_p1, wr_p1[k]) - mul_p(xi_p1, wi_p1[k]);
                pi_p2[k] <= mul_p(xr_p1, wi_p1[k]) + mul_p(xi_p1, wr_p1[k]);
            end
        end
    end

    always_comb begin
        any_ovf = 1'b0;
        for (int k = 0; k < NUM_BINS; k++) begin
            sum_re[k] = sat_add(acc_re[k], scale(pr_p2[k]));
            sum_im[k] = sat_add(acc_im[k], scale(pi_p2[k]));
            any_ovf   = any_ovf | sum_re[k][ACCUM_WIDTH] | sum_im[k][ACCUM_WIDTH];
        end
    end

    // Stage 3: saturating accumulation, sticky overflow, sample count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || run_start) begin
            for (int k = 0; k < NUM_BINS; k++) begin
                acc_re[k] <= '0;
                acc_im[k] <= '0;
            end
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            if (vld_p2) begin
                for (int k = 0; k < NUM_BINS; k++) begin
                    acc_re[k] <= sum_re[k][ACCUM_WIDTH-1:0];
                    acc_im[k] <= sum_im[k][ACCUM_WIDTH-1:0];
                end
                if (any_ovf) ovf_q <= 1'b1;
            end
            if (accept && !(&count_q)) count_q <= count_q + 1'b1;
        end
    end

    assign bus.s_ready_o      = (state == ACCUM);
    assign bus.m_valid_o      = (state == OUTPUT);
    assign bus.m_bin_o        = bin_idx;
    assign bus.m_real_o       = (state == OUTPUT) ? acc_re[bin_idx] : '0;
    assign bus.m_imag_o       = (state == OUTPUT) ? acc_im[bin_idx] : '0;
    assign bus.m_last_o       = (state == OUTPUT) && (bin_idx == BIN_W'(NUM_BINS - 1));
    assign bus.ovf_o          = ovf_q;
    assign bus.sample_count_o = count_q;
    assign bus.busy_o         = (state != IDLE);
endmodule

// File: tb/tb_dft_accum_stream.sv
// Scoreboard bench for dft_accum_stream: directed runs plus randomized runs
// checked against an integer reference model of the windowed DFT accumulation.
module tb_dft_accum_stream;
    localparam int IQW = 16, WW = 16, OW = 18, AW = 24, NB = 4, PS = 0, SCW = 16;
    localparam int CNT_MAX = (1 << SCW) - 1;

    typedef struct {
        int     bin;
        longint re;
        longint im;
        bit     last;
        bit     ovf;
        int     cnt;
    } exp_t;

    typedef struct {
        longint i;
        longint q;
        longint h;
        longint wr [NB];
        longint wi [NB];
    } smp_t;

    logic clk = 1'b0;
    logic rst_n;
    bit   rdy_rand, rdy_force;
    int   vectors = 0, miscompares = 0;
    exp_t exp_q[$];
    longint m_re [NB];
    longint m_im [NB];
    bit     m_ovf;
    int     m_cnt;

    always #5 clk = ~clk;

    dft_accum_stream_if #(.IQ_WIDTH(IQW), .WINDOW_WIDTH(WW), .OSC_WIDTH(OW),
                          .ACCUM_WIDTH(AW), .NUM_BINS(NB), .SAMPLE_COUNT_WIDTH(SCW)) bus ();

    dft_accum_stream #(.IQ_WIDTH(IQW), .WINDOW_WIDTH(WW), .OSC_WIDTH(OW), .ACCUM_WIDTH(AW),
                       .NUM_BINS(NB), .PROD_SHIFT(PS), .SAMPLE_COUNT_WIDTH(SCW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic longint wrapn(input longint v, input int n);
        longint m;
        m = v & ((longint'(1) << n) - 1);
        if (m >= (longint'(1) << (n - 1))) m -= (longint'(1) << n);
        return m;
    endfunction

    // One accumulation step: scale, fit to AW+1 bits, add, clamp to AW bits.
    function automatic longint acc_step(input longint a, input longint p);
        longint t, s, hi, lo;
        hi = (longint'(1) << (AW - 1)) - 1;
        lo = -(longint'(1) << (AW - 1));
        t  = p;
        if (PS > 0) t = (p + (longint'(1) << ((PS > 0) ? PS - 1 : 0))) >>> PS;
        t = wrapn(t, AW + 1);
        s = wrapn(a + t, AW + 1);
        if (s > hi) begin s = hi; m_ovf = 1'b1; end
        if (s < lo) begin s = lo; m_ovf = 1'b1; end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin m_re[k] = 0; m_im[k] = 0; end
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_apply(input smp_t s);
        longint xr, xi, pr, pim;
        xr = s.i * s.h;
        xi = s.q * s.h;
        for (int k = 0; k < NB; k++) begin
            pr  = xr * s.wr[k] - xi * s.wi[k];
            pim = xr * s.wi[k] + xi * s.wr[k];
            m_re[k] = acc_step(m_re[k], pr);
            m_im[k] = acc_step(m_im[k], pim);
        end
        if (m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic push_results();
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            e.bin = k; e.re = m_re[k]; e.im = m_im[k];
            e.last = (k == NB - 1); e.ovf = m_ovf; e.cnt = m_cnt;
            exp_q.push_back(e);
        end
    endtask

    function automatic smp_t mk(input longint i, input longint q, input longint h,
                                input longint wr0, input longint wrk, input longint wi0);
        smp_t s;
        s.i = i; s.q = q; s.h = h;
        for (int k = 0; k < NB; k++) begin s.wr[k] = wr0 + wrk * k; s.wi[k] = wi0; end
        return s;
    endfunction

    function automatic smp_t rnd_smp(input bit full);
        smp_t s;
        if (full) begin
            s.i = wrapn(longint'($urandom), IQW);
            s.q = wrapn(longint'($urandom), IQW);
            s.h = wrapn(longint'($urandom), WW);
            for (int k = 0; k < NB; k++) begin
                s.wr[k] = wrapn(longint'($urandom), OW);
                s.wi[k] = wrapn(longint'($urandom), OW);
            end
        end else begin
            s.i = longint'($urandom_range(0, 400)) - 200;
            s.q = longint'($urandom_range(0, 400)) - 200;
            s.h = longint'($urandom_range(0, 100)) - 50;
            for (int k = 0; k < NB; k++) begin
                s.wr[k] = longint'($urandom_range(0, 2000)) - 1000;
                s.wi[k] = longint'($urandom_range(0, 2000)) - 1000;
            end
        end
        return s;
    endfunction

    task automatic send(input smp_t s, input bit last);
        bus.i_sample_i     = IQW'(s.i);
        bus.q_sample_i     = IQW'(s.q);
        bus.window_coeff_i = WW'(s.h);
        for (int k = 0; k < NB; k++) begin
            bus.W_real_i[k] = OW'(s.wr[k]);
            bus.W_imag_i[k] = OW'(s.wi[k]);
        end
        bus.s_valid_i = 1'b1;
        bus.s_last_i  = last;
        @(negedge clk);
        check("s_ready_o during ACCUM", bus.s_ready_o, 1);
        @(posedge clk); #1;
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        model_apply(s);
        if (last) push_results();
    endtask

    // Invalid cycle carrying junk data that must not reach the sums.
    task automatic idle_cycle();
        bus.i_sample_i     = IQW'($urandom);
        bus.q_sample_i     = IQW'($urandom);
        bus.window_coeff_i = WW'($urandom);
        for (int k = 0; k < NB; k++) begin
            bus.W_real_i[k] = OW'($urandom);
            bus.W_imag_i[k] = OW'($urandom);
        end
        bus.s_valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic start_run();
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        model_reset();
        check("busy_o after start", bus.busy_o, 1);
        check("ovf_o cleared by start", bus.ovf_o, 0);
        check("sample_count_o cleared by start", bus.sample_count_o, 0);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!bus.busy_o && exp_q.size() == 0) break;
        end
        check("drain busy_o", bus.busy_o, 0);
        check("drain pending results", exp_q.size(), 0);
    endtask

    // Backpressure driver (sole writer of m_ready_i).
    initial begin
        bus.m_ready_i = 1'b0;
        forever begin
            @(posedge clk); #2;
            bus.m_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: pops the scoreboard on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.m_valid_o && bus.m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("spurious result m_valid_o", bus.m_valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("bin%0d m_bin_o", e.bin), bus.m_bin_o, e.bin);
                    check($sformatf("bin%0d m_real_o", e.bin), bus.m_real_o, e.re);
                    check($sformatf("bin%0d m_imag_o", e.bin), bus.m_imag_o, e.im);
                    check($sformatf("bin%0d m_last_o", e.bin), bus.m_last_o, e.last);
                    check($sformatf("bin%0d ovf_o", e.bin), bus.ovf_o, e.ovf);
                    check($sformatf("bin%0d sample_count_o", e.bin), bus.sample_count_o, e.cnt);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rdy_rand = 1'b0; rdy_force = 1'b1;
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0;
        bus.i_sample_i = '0; bus.q_sample_i = '0; bus.window_coeff_i = '0;
        for (int k = 0; k < NB; k++) begin bus.W_real_i[k] = '0; bus.W_imag_i[k] = '0; end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset s_ready_o", bus.s_ready_o, 0);
        check("reset m_valid_o", bus.m_valid_o, 0);
        check("reset m_bin_o", bus.m_bin_o, 0);
        check("reset m_real_o", bus.m_real_o, 0);
        check("reset m_imag_o", bus.m_imag_o, 0);
        check("reset m_last_o", bus.m_last_o, 0);
        check("reset ovf_o", bus.ovf_o, 0);
        check("reset sample_count_o", bus.sample_count_o, 0);
        check("reset busy_o", bus.busy_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant real tone: every bin (2400, 0).
        start_run();
        for (int n = 0; n < 4; n++) send(mk(100, 0, 2, 3, 0, 0), n == 3);
        wait_idle();

        // Quadrature oscillator, result latency after the last acceptance.
        start_run();
        for (int n = 0; n < 3; n++) send(mk(1, 1, 1, 0, 0, 1), n == 2);
        @(posedge clk); #1;
        check("m_valid_o one cycle after last", bus.m_valid_o, 0);
        @(posedge clk); #1;
        check("m_valid_o two cycles after last", bus.m_valid_o, 1);
        wait_idle();

        // Gapped input with per-bin W = (k, 0).
        start_run();
        for (int n = 0; n < 8; n++) begin
            send(mk(5, 0, 1, 0, 1, 0), n == 7);
            if (n != 7) idle_cycle();
        end
        wait_idle();

        // Saturation: positive clamp, sticky ovf_o.
        start_run();
        for (int n = 0; n < 50; n++) send(mk(32767, 0, 32767, 131071, 0, 0), n == 49);
        wait_idle();
        check("ovf_o sticky after run", bus.ovf_o, 1);

        // Next start clears ovf_o; stall on bin 1.
        start_run();
        for (int n = 0; n < 4; n++) send(mk(7, -3, 2, 11, 5, -4), n == 3);
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (bus.m_valid_o && bus.m_bin_o == 1) break;
        end
        check("stall reached bin 1", bus.m_bin_o, 1);
        rdy_force = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall m_valid_o", bus.m_valid_o, 1);
            check("stall m_bin_o", bus.m_bin_o, 1);
            check("stall m_real_o", bus.m_real_o, m_re[1]);
            check("stall m_imag_o", bus.m_imag_o, m_im[1]);
        end
        rdy_force = 1'b1;
        wait_idle();

        // Abort mid-ACCUM, then abort+start together in IDLE.
        start_run();
        send(rnd_smp(1'b0), 1'b0);
        send(rnd_smp(1'b0), 1'b0);
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        check("abort busy_o", bus.busy_o, 0);
        check("abort m_valid_o", bus.m_valid_o, 0);
        check("abort s_ready_o", bus.s_ready_o, 0);
        bus.abort_i = 1'b1; bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0; bus.start_i = 1'b0;
        check("abort+start busy_o", bus.busy_o, 0);
        start_run();
        for (int n = 0; n < 3; n++) send(rnd_smp(1'b0), n == 2);
        wait_idle();

        // Reset while results are pending.
        rdy_force = 1'b0;
        start_run();
        for (int n = 0; n < 3; n++) send(rnd_smp(1'b0), n == 2);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.m_valid_o) break;
        end
        check("m_valid_o before reset", bus.m_valid_o, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset mid-output busy_o", bus.busy_o, 0);
        check("reset mid-output m_valid_o", bus.m_valid_o, 0);
        check("reset mid-output m_real_o", bus.m_real_o, 0);
        check("reset mid-output sample_count_o", bus.sample_count_o, 0);
        rst_n = 1'b1;
        exp_q.delete();
        rdy_force = 1'b1;
        @(posedge clk); #1;

        // Minimum run: last on the first sample.
        start_run();
        send(rnd_smp(1'b0), 1'b1);
        wait_idle();

        // Randomized runs with gaps and backpressure.
        rdy_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            int  len;
            bit  full;
            len  = $urandom_range(1, 10);
            full = (r % 3 == 2);
            start_run();
            for (int n = 0; n < len; n++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
                send(rnd_smp(full), n == len - 1);
            end
            wait_idle();
        end
        rdy_rand = 1'b0;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dft_accum_stream.md
# dft_accum_stream

Next-generation windowed-DFT bin accumulator for the AFE → DFT path. Per accepted complex sample x[n] = I + jQ, it computes x[n]·h[n]·W[n,k] for NUM_BINS bins in a fully registered pipeline, with tag-aligned W delay, rounding, saturating accumulation and a sticky overflow flag. After the last sample it drains the pipeline and streams the bin results out serially over a valid/ready port to the APU.

## Interface
- IQ_WIDTH, 16, signed I/Q sample width
- WINDOW_WIDTH, 16, signed window coefficient width
- OSC_WIDTH, 18, signed oscillator real/imag width
- ACCUM_WIDTH, 48, signed accumulator width per real/imag part
- NUM_BINS, 16, bin count (≥1)
- PROD_SHIFT, 0, arithmetic right shift applied to each complex product before accumulation, with round-half-up
- SAMPLE_COUNT_WIDTH, 16, sample counter width
- clk_i  in  1  clock; all logic on posedge
- rst_ni  in  1  synchronous, active-low reset
- start_i  in  1  begin a run; honoured only in IDLE
- abort_i  in  1  cancel the run; highest priority after reset
- s_valid_i  in  1  sample valid
- s_ready_o  out  1  sample ready; 1 only in ACCUM
- s_last_i  in  1  marks the final sample of the run
- i_sample_i, q_sample_i  in  IQ_WIDTH each  signed I/Q
- window_coeff_i  in  WINDOW_WIDTH  h[n], same cycle as the sample
- W_real_i[NUM_BINS], W_imag_i[NUM_BINS]  in  OSC_WIDTH each  W[n,k], same cycle as the sample
- m_valid_o  out  1  result valid
- m_ready_i  in  1  result ready
- m_bin_o  out  $clog2(NUM_BINS) (min 1)  bin index
- m_real_o, m_imag_o  out  ACCUM_WIDTH each  signed A[k]
- m_last_o  out  1  high with bin NUM_BINS-1
- ovf_o  out  1  sticky saturation flag for the current run
- sample_count_o  out  SAMPLE_COUNT_WIDTH  samples accepted in the run
- busy_o  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, FLUSH, OUTPUT.
- **IDLE → ACCUM** on start_i: clear all accumulators, ovf_o and sample_count_o.
- **ACCUM:** a sample is accepted when s_valid_i && s_ready_o. Acceptance of the s_last_i sample → FLUSH.
- **FLUSH:** lasts exactly 2 cycles (pipeline drain), then → OUTPUT with bin index 0.
- **OUTPUT:** m_valid_o=1 and shows bin idx. The index increments on each handshake. Handshake with m_last_o → IDLE. While m_ready_i=0, outputs are held stable.
- **Abort:** abort_i in any state → IDLE next cycle. All pipeline valid tags clear and no result is emitted. Accumulator contents are don't-care until the next start.
- Outside IDLE, start_i is ignored. In IDLE, s_valid_i is ignored (s_ready_o=0).
- **Pipeline:**
  - Stage 1 registers xr = I·h and xi = Q·h (IQ_WIDTH+WINDOW_WIDTH bits each), plus a copy of all W and a valid tag.
  - Stage 2 registers pr = xr·Wr − xi·Wi and pi = xr·Wi + xi·Wr per bin, at full width P = IQ_WIDTH+WINDOW_WIDTH+OSC_WIDTH+1, plus the tag.
  - Stage 3 accumulates when the stage-2 tag is set.
- **Scaling:** if PROD_SHIFT>0, term = (p + 2^(PROD_SHIFT−1)) >>> PROD_SHIFT, else term = p. The term is sign-extended or truncated to ACCUM_WIDTH+1.
- **Accumulation:** sum = A + term at ACCUM_WIDTH+1 bits. On overflow, clamp to +2^(ACCUM_WIDTH−1)−1 or −2^(ACCUM_WIDTH−1) and set ovf_o. ovf_o stays set until the next start_i.
- **sample_count_o:** increments per accepted sample and saturates at all-ones.

## Timing
- **Reset** (rst_ni=0 at a posedge): state IDLE. Outputs s_ready_o, m_valid_o, m_bin_o, m_real_o, m_imag_o, m_last_o, ovf_o, sample_count_o and busy_o are all 0. Pipeline tags and accumulators are 0. Reset mid-run behaves the same and loses the run.
- **Accept-to-accumulate latency:** a sample accepted at edge E0 is in A[k] after edge E0+2.
- **Result latency:** if the last sample is accepted at edge E0, m_valid_o rises after edge E0+2. The first result is A including the last sample.
- **Gapped input:** s_valid_i gaps in ACCUM are legal. Tags keep gaps out of the sums and W alignment follows the tag.
- **Minimum run:** a run with s_last_i on the first sample is legal. Back-to-back runs need one IDLE cycle with start_i.
- **Abort and start together:** abort_i and start_i in the same IDLE cycle → abort wins and the block stays in IDLE.

## Test plan
- Bench config NUM_BINS=4, PROD_SHIFT=0. Start, then 4 samples with I=100, Q=0, h=2, W=(3,0) on all bins, last on the 4th. Required: 4 results, bins 0..3, each (2400, 0), m_last_o on bin 3, sample_count_o=4, ovf_o=0.
- Start, then 3 samples with I=1, Q=1, h=1, W[k]=(0,1). Required: every bin (−3, 3), first m_valid_o exactly 2 cycles after the last acceptance.
- Start, then 8 samples with s_valid_i toggled 1/0 and W[k]=(k,0), I=5, Q=0, h=1, last on the 8th. Required: bin k = (40k, 0), with no contribution from idle cycles.
- Bench config ACCUM_WIDTH=24. Repeated samples with I=h=32767, W=(131071,0). Required: bins clamp at 8388607 and ovf_o=1. ovf_o clears on the next start_i.
- Hold m_ready_i=0 for 5 cycles on bin 1. Required: outputs stable, then bins 1..3 delivered in order.
- abort_i mid-ACCUM and rst_ni=0 mid-OUTPUT. Required: IDLE next cycle, m_valid_o=0, busy_o=0, and no spurious results on the following run.
